// File: rtl/seq_multiplier_n_bit.sv
// Iterative radix-2 shift-add multiplier producing a full 2*WIDTH product,
// signed or unsigned, with a start/busy/done handshake and low-half overflow flag.
module seq_multiplier_n_bit #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 signed_mode,
    input  logic [WIDTH-1:0]     in_a,
    input  logic [WIDTH-1:0]     in_b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product,
    output logic [WIDTH-1:0]     out,
    output logic                 overflow
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0]     mcand_q, mcand_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic                 neg_q, neg_d;
    logic                 smode_q, smode_d;
    logic [2*WIDTH-1:0]   product_q, product_d;
    logic                 overflow_q, overflow_d;

    logic [WIDTH:0]       sum;
    logic [2*WIDTH-1:0]   acc_step;
    logic [2*WIDTH-1:0]   final_p;

    // Signed operands are multiplied as magnitudes; the sign is reapplied at the end.
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic sm);
        return (sm && v[WIDTH-1]) ? -v : v;
    endfunction

    function automatic logic low_half_overflow(input logic [2*WIDTH-1:0] p, input logic sm);
        if (sm)
            return p[2*WIDTH-1:WIDTH] != {WIDTH{p[WIDTH-1]}};
        return p[2*WIDTH-1:WIDTH] != '0;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            mcand_q    <= '0;
            acc_q      <= '0;
            neg_q      <= 1'b0;
            smode_q    <= 1'b0;
            product_q  <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            mcand_q    <= mcand_d;
            acc_q      <= acc_d;
            neg_q      <= neg_d;
            smode_q    <= smode_d;
            product_q  <= product_d;
            overflow_q <= overflow_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_RUN;
            S_RUN:   if (cnt_q == CNT_W'(1)) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Upper accumulator half collects partial sums; the lower half holds the
    // multiplier, consumed one LSB per step as the pair shifts right.
    always_comb begin
        sum      = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
        acc_step = {sum, acc_q[WIDTH-1:1]};
        final_p  = (neg_q && acc_step != '0) ? -acc_step : acc_step;

        cnt_d      = cnt_q;
        mcand_d    = mcand_q;
        acc_d      = acc_q;
        neg_d      = neg_q;
        smode_d    = smode_q;
        product_d  = product_q;
        overflow_d = overflow_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    mcand_d = magnitude(in_a, signed_mode);
                    acc_d   = {{WIDTH{1'b0}}, magnitude(in_b, signed_mode)};
                    neg_d   = signed_mode & (in_a[WIDTH-1] ^ in_b[WIDTH-1]);
                    smode_d = signed_mode;
                    cnt_d   = CNT_W'(WIDTH);
                end
            end
            S_RUN: begin
                acc_d = acc_step;
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    product_d  = final_p;
                    overflow_d = low_half_overflow(final_p, smode_q);
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        busy     = (state_q != S_IDLE);
        done     = (state_q == S_DONE);
        product  = product_q;
        out      = product_q[WIDTH-1:0];
        overflow = overflow_q;
    end

endmodule
